// File: rtl/vector_sweep_checker.sv
// Stimulus-and-check engine: drives exhaustive or LFSR vectors into a DUT,
// compares its response against a golden model and records run statistics.
module vector_sweep_checker #(
    parameter int unsigned N_IN      = 3,
    parameter int unsigned N_OUT     = 2,
    parameter int unsigned SETTLE    = 1,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             mode,
    input  logic [15:0]      num_vec,
    output logic [N_IN-1:0]  stim,
    input  logic [N_OUT-1:0] dut_out,
    input  logic [N_OUT-1:0] gold_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [15:0]      err_count,
    output logic [15:0]      vec_count,
    output logic [N_IN-1:0]  first_fail_vec,
    output logic             first_fail_valid
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [15:0] SEED     = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam logic [7:0]  SETTLE_C = 8'(SETTLE);
    localparam logic [15:0] POLY     = 16'hB400;

    state_t            state_q, state_d;
    logic [N_IN-1:0]   stim_q, stim_d;
    logic [15:0]       lfsr_q, lfsr_d;
    logic [7:0]        hold_q, hold_d;
    logic [15:0]       err_q, err_d;
    logic [15:0]       vec_q, vec_d;
    logic [N_IN-1:0]   ffv_q, ffv_d;
    logic              ffvalid_q, ffvalid_d;
    logic              done_q, done_d;
    logic              mode_q, mode_d;
    logic [15:0]       numvec_q, numvec_d;

    logic [15:0]       lfsr_next;
    logic              mismatch;
    logic              last_vec;

    assign lfsr_next = lfsr_q[0] ? ((lfsr_q >> 1) ^ POLY) : (lfsr_q >> 1);
    assign mismatch  = (dut_out != gold_out);
    assign last_vec  = mode_q ? ((vec_q + 16'd1) == numvec_q) : (stim_q == '1);

    always_comb begin
        state_d   = state_q;
        stim_d    = stim_q;
        lfsr_d    = lfsr_q;
        hold_d    = hold_q;
        err_d     = err_q;
        vec_d     = vec_q;
        ffv_d     = ffv_q;
        ffvalid_d = ffvalid_q;
        done_d    = done_q;
        mode_d    = mode_q;
        numvec_d  = numvec_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    err_d     = '0;
                    vec_d     = '0;
                    ffv_d     = '0;
                    ffvalid_d = 1'b0;
                    mode_d    = mode;
                    numvec_d  = num_vec;
                    lfsr_d    = SEED;
                    hold_d    = '0;
                    done_d    = 1'b0;
                    if (mode && (num_vec == 16'd0)) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        stim_d  = '0;
                    end else begin
                        state_d = RUN;
                        stim_d  = mode ? SEED[N_IN-1:0] : '0;
                    end
                end
            end
            RUN: begin
                if (hold_q == SETTLE_C) begin
                    // Sample edge: score this vector, then either finish or advance.
                    hold_d = '0;
                    vec_d  = vec_q + 16'd1;
                    if (mismatch) begin
                        if (err_q != 16'hFFFF) begin
                            err_d = err_q + 16'd1;
                        end
                        if (!ffvalid_q) begin
                            ffv_d     = stim_q;
                            ffvalid_d = 1'b1;
                        end
                    end
                    if (last_vec) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else if (mode_q) begin
                        lfsr_d = lfsr_next;
                        stim_d = lfsr_next[N_IN-1:0];
                    end else begin
                        stim_d = stim_q + N_IN'(1);
                    end
                end else begin
                    hold_d = hold_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            stim_q    <= '0;
            lfsr_q    <= SEED;
            hold_q    <= '0;
            err_q     <= '0;
            vec_q     <= '0;
            ffv_q     <= '0;
            ffvalid_q <= 1'b0;
            done_q    <= 1'b0;
            mode_q    <= 1'b0;
            numvec_q  <= '0;
        end else begin
            state_q   <= state_d;
            stim_q    <= stim_d;
            lfsr_q    <= lfsr_d;
            hold_q    <= hold_d;
            err_q     <= err_d;
            vec_q     <= vec_d;
            ffv_q     <= ffv_d;
            ffvalid_q <= ffvalid_d;
            done_q    <= done_d;
            mode_q    <= mode_d;
            numvec_q  <= numvec_d;
        end
    end

    assign stim             = stim_q;
    assign busy             = (state_q == RUN);
    assign done             = done_q;
    assign pass             = done_q && (err_q == 16'd0);
    assign err_count        = err_q;
    assign vec_count        = vec_q;
    assign first_fail_vec   = ffv_q;
    assign first_fail_valid = ffvalid_q;

endmodule

// File: tb/tb_vector_sweep_checker.sv
// Directed bench for vector_sweep_checker: table of runs plus hand-written
// sequences for stimulus ordering, busy-start, mid-run reset and saturation.
module tb_vector_sweep_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start, mode, fault;
    logic [15:0] num_vec;
    logic [2:0]  stim;
    logic [1:0]  dut_out, gold_out;
    logic        busy, done, pass;
    logic [15:0] err_count, vec_count;
    logic [2:0]  ffv;
    logic        ffvalid;

    logic        start_s;
    logic [15:0] stim_s;
    logic [1:0]  dut_s, gold_s;
    logic        busy_s, done_s, pass_s;
    logic [15:0] err_s, vec_s, ffv_s;
    logic        ffvalid_s;

    int unsigned checks = 0;
    int unsigned errors = 0;

    function automatic logic [1:0] ref_fn(input logic [2:0] v);
        return {v[2] ^ v[0], v[1] | v[0]};
    endfunction

    assign gold_out = ref_fn(stim);
    assign dut_out  = ref_fn(stim) ^ {1'b0, fault && ((stim == 3'd5) || (stim == 3'd6))};

    assign dut_s  = stim_s[1:0];
    assign gold_s = ~dut_s;

    vector_sweep_checker #(.N_IN(3), .N_OUT(2), .SETTLE(1), .LFSR_SEED(16'hACE1)) u_dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .num_vec(num_vec),
        .stim(stim), .dut_out(dut_out), .gold_out(gold_out), .busy(busy),
        .done(done), .pass(pass), .err_count(err_count), .vec_count(vec_count),
        .first_fail_vec(ffv), .first_fail_valid(ffvalid)
    );

    vector_sweep_checker #(.N_IN(16), .N_OUT(2), .SETTLE(0), .LFSR_SEED(16'hACE1)) u_sat (
        .clk(clk), .reset(reset), .start(start_s), .mode(1'b0), .num_vec(16'd0),
        .stim(stim_s), .dut_out(dut_s), .gold_out(gold_s), .busy(busy_s),
        .done(done_s), .pass(pass_s), .err_count(err_s), .vec_count(vec_s),
        .first_fail_vec(ffv_s), .first_fail_valid(ffvalid_s)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        mode;
        logic [15:0] nv;
        logic        fault;
        int unsigned edges;
        logic [15:0] err;
        logic [15:0] vec;
        logic        ffvalid;
        logic [2:0]  ffv;
        logic        pass;
    } run_t;

    task automatic run_entry(input run_t e);
        int unsigned edges;
        @(negedge clk);
        mode = e.mode; num_vec = e.nv; fault = e.fault; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (e.edges == 0) begin
            chk("zero_vec_done", {busy, done, pass, stim}, {1'b0, 1'b1, 1'b1, 3'd0});
        end else begin
            chk("accept_clear", {busy, done, pass, err_count, vec_count, ffvalid, ffv},
                {1'b1, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0, 3'd0});
            chk("first_stim", 64'(stim), e.mode ? 64'd1 : 64'd0);
        end
        edges = 0;
        while (!done && edges < 200) begin
            @(posedge clk); @(negedge clk);
            edges++;
        end
        chk("done_latency", 64'(edges), 64'(e.edges));
        repeat (2) @(negedge clk);
        chk("err_count", 64'(err_count), 64'(e.err));
        chk("vec_count", 64'(vec_count), 64'(e.vec));
        chk("first_fail", {ffvalid, ffv}, {e.ffvalid, e.ffv});
        chk("pass_done_busy", {pass, done, busy}, {e.pass, 1'b1, 1'b0});
    endtask

    run_t tbl[8];
    logic [2:0] lfsr_seq[5];

    initial begin
        tbl[0] = '{1'b0, 16'd3,  1'b0, 16, 16'd0, 16'd8,  1'b0, 3'd0, 1'b1};
        tbl[1] = '{1'b0, 16'd0,  1'b1, 16, 16'd2, 16'd8,  1'b1, 3'd5, 1'b0};
        tbl[2] = '{1'b0, 16'd0,  1'b1, 16, 16'd2, 16'd8,  1'b1, 3'd5, 1'b0};
        tbl[3] = '{1'b1, 16'd5,  1'b0, 10, 16'd0, 16'd5,  1'b0, 3'd0, 1'b1};
        tbl[4] = '{1'b1, 16'd0,  1'b0, 0,  16'd0, 16'd0,  1'b0, 3'd0, 1'b1};
        tbl[5] = '{1'b1, 16'd5,  1'b1, 10, 16'd1, 16'd5,  1'b1, 3'd6, 1'b0};
        tbl[6] = '{1'b1, 16'd12, 1'b1, 24, 16'd1, 16'd12, 1'b1, 3'd6, 1'b0};
        tbl[7] = '{1'b1, 16'd1,  1'b0, 2,  16'd0, 16'd1,  1'b0, 3'd0, 1'b1};
        lfsr_seq = '{3'd1, 3'd0, 3'd0, 3'd4, 3'd6};

        reset = 1'b1; start = 1'b0; mode = 1'b0; num_vec = 16'd0; fault = 1'b0; start_s = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("reset_state", {stim, busy, done, pass, err_count, vec_count, ffv, ffvalid}, 64'd0);

        // Exhaustive sweep: each vector held two cycles; a start pulse mid-run is ignored.
        @(negedge clk);
        mode = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 16; c++) begin
            chk("sweep_stim", {busy, 13'd0, stim}, {1'b1, 13'd0, 3'(c / 2)});
            if (c == 5) begin start = 1'b1; mode = 1'b1; num_vec = 16'd2; end
            else start = 1'b0;
            @(posedge clk); @(negedge clk);
        end
        start = 1'b0; mode = 1'b0;
        chk("sweep_result", {done, busy, pass, err_count, vec_count, ffvalid},
            {1'b1, 1'b0, 1'b1, 16'd0, 16'd8, 1'b0});

        // LFSR sequence from seed 16'hACE1.
        @(negedge clk);
        mode = 1'b1; num_vec = 16'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 10; c++) begin
            chk("lfsr_stim", 64'(stim), 64'(lfsr_seq[c / 2]));
            @(posedge clk); @(negedge clk);
        end
        chk("lfsr_result", {done, pass, vec_count}, {1'b1, 1'b1, 16'd5});

        // Reset mid-run after a failure has been captured.
        @(negedge clk);
        mode = 1'b0; fault = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (13) begin @(posedge clk); @(negedge clk); end
        chk("pre_reset", {stim, err_count, ffvalid, ffv, busy}, {3'd6, 16'd1, 1'b1, 3'd5, 1'b1});
        reset = 1'b1;
        @(posedge clk); @(negedge clk);
        reset = 1'b0;
        chk("mid_run_reset", {stim, busy, done, pass, err_count, vec_count, ffv, ffvalid}, 64'd0);
        @(posedge clk); @(negedge clk);
        chk("idle_after_reset", {busy, done, stim}, 64'd0);

        for (int i = 0; i < 8; i++) run_entry(tbl[i]);

        // 65536 mismatching vectors: error count must saturate, vector count wraps.
        @(negedge clk);
        start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        begin
            int unsigned edges = 0;
            while (!done_s && edges < 70000) begin
                @(posedge clk); @(negedge clk);
                edges++;
            end
            chk("sat_latency", 64'(edges), 64'd65536);
        end
        chk("sat_err", 64'(err_s), 64'hFFFF);
        chk("sat_vec_wrap", 64'(vec_s), 64'd0);
        chk("sat_flags", {pass_s, busy_s, ffvalid_s, ffv_s}, {1'b0, 1'b0, 1'b1, 16'd0});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vector_sweep_checker.md
Name: vector_sweep_checker

Overview:
Synthesizable, parametrised stimulus-and-check engine for small combinational blocks. It drives an N_IN-bit input vector into a device under test and samples the DUT outputs after a configurable settle time. It compares those outputs with a golden-model output and records the pass/fail result, the error count and the first failing vector. Vectors come either from an exhaustive ascending sweep or from an LFSR pseudo-random sequence. It sits between a DUT and its golden reference on the lab board or in a bench, and replaces hand-written per-vector stimulus lists.

Parameters:
N_IN, 3, DUT input width (1..16)
N_OUT, 2, DUT output width (1..32)
SETTLE, 1, extra hold cycles per vector before sampling (0..255)
LFSR_SEED, 16'hACE1, LFSR start state; a value of 0 is replaced by 16'h0001

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle request to begin a run; ignored while busy=1
mode  input  1  0 = exhaustive sweep, 1 = LFSR random
num_vec  input  16  vector count in mode 1; ignored in mode 0
stim  output  N_IN  vector driven to DUT and golden model
dut_out  input  N_OUT  DUT response
gold_out  input  N_OUT  expected response
busy  output  1  run in progress
done  output  1  run finished; held until next accepted start or reset
pass  output  1  done=1 and err_count=0
err_count  output  16  mismatch count, saturates at 16'hFFFF
vec_count  output  16  number of vectors sampled so far
first_fail_vec  output  N_IN  stim value of the first mismatch
first_fail_valid  output  1  first_fail_vec holds a captured value

Behaviour:
- Reset (sync, on clk edge while reset=1): state IDLE; stim=0, busy=0, done=0, pass=0, err_count=0, vec_count=0, first_fail_vec=0, first_fail_valid=0; LFSR=LFSR_SEED (0 replaced by 1). Reset overrides start and any run in progress.
- States: IDLE, RUN, DONE.
- Start acceptance (IDLE or DONE, start=1, edge k):
  - Clear done, pass, err_count, vec_count, first_fail_*; latch mode and num_vec.
  - Reload the LFSR from the seed.
  - Load stim with the first vector: 0 in mode 0, or LFSR[N_IN-1:0] in mode 1 (seed value).
  - Set busy=1 and go to RUN.
- Start with mode=1 and num_vec=0: go directly to DONE with done=1, pass=1, busy=0, stim=0.
- RUN:
  - Each vector holds stim stable for SETTLE+1 cycles; a hold counter counts 0..SETTLE.
  - On the edge where the counter equals SETTLE (sample edge): compare dut_out with gold_out.
    - On mismatch: err_count+1, saturating.
    - On mismatch with first_fail_valid=0: first_fail_vec=stim and first_fail_valid=1.
    - vec_count+1 on every sample edge.
  - Same sample edge, if this was the last vector: go to DONE; busy=0, done=1, pass=(final err_count==0); stim keeps the last vector.
  - Same sample edge, otherwise: advance stim.
    - Mode 0: stim+1.
    - Mode 1: Galois right-shift LFSR, polynomial mask 16'hB400 (if lsb=1, next=(s>>1)^16'hB400, else next=s>>1); stim=next[N_IN-1:0].
- Last vector: mode 0 when stim equals all ones (2^N_IN vectors total); mode 1 when vec_count+1 equals the latched num_vec.
- Timing: done rises V*(SETTLE+1) cycles after the start-accept edge, where V is the vector count.
- start=1 while busy is ignored and has no effect on the run.
- DONE holds all results stable until the next accepted start or reset.
- Counters are 16 bits wide. An exhaustive run with N_IN=16 (65536 vectors) reports vec_count wrapped to 0; use err_count and done, not vec_count, for completion in that case.

Test Plan:
1. N_IN=3, SETTLE=1, mode 0, gold_out tied to dut_out -> stim steps 0..7, each held 2 cycles; done=1 exactly 16 cycles after the start edge; pass=1, err_count=0, vec_count=8, first_fail_valid=0.
2. Same setup, DUT faulted so dut_out differs from gold_out for stim=5 and stim=6 -> err_count=2, first_fail_vec=3'b101, first_fail_valid=1, pass=0, done=1.
3. Mode 1, num_vec=5, seed 16'hACE1, N_IN=3 -> stim sequence 1,0,0,4,6 (LFSR states ACE1, E270, 7138, 389C, 1C4E); vec_count=5, done after 10 cycles. Also mode 1 with num_vec=0 -> done=1, pass=1 one cycle after start.
4. Pulse start again while busy in test 1 -> ignored, run completes unchanged. Assert reset during the 4th vector -> next edge: busy=0, stim=0, err_count=0, state IDLE; a new start runs cleanly from stim=0.
5. From DONE with err_count=2, issue start -> counters and first_fail_* cleared on the accept edge; run repeats with identical results.
6. Mode 1, num_vec=16'hFFFF, gold_out forced to ~dut_out -> err_count=16'hFFFF (saturated, no wrap), pass=0, vec_count=16'hFFFF.
